mem_stage: RTL and testbench

- Memory-access stage of the 5-stage RISC-V pipeline. Sits between the EX/MEM pipeline register and the MEM/WB register.
- Issues loads and stores to the data-memory bus over a req/ack handshake and stalls the pipeline while a transfer is outstanding.
- Aligns and sign/zero-extends load data.
- Passes non-memory instructions straight through to MEM/WB as `data`, `rd` and `reg_en`.

---
 rtl/mem_stage.sv | 211 +++++++++++++++++++++
 tb/tb_mem_stage.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - RV32I memory-access stage: bus req/ack handshake, pipeline stall, load alignment
module mem_stage #(
  parameter int BUS_TIMEOUT = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] alu_result,
  input  logic [31:0] store_data,
  input  logic [4:0]  rd_in,
  input  logic        reg_en_in,
  output logic [31:0] data_out,
  output logic [4:0]  rd_out,
  output logic        reg_en_out,
  output logic        stall,
  output logic        addr_fault,
  output logic        bus_error,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'((BUS_TIMEOUT > 0) ? BUS_TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [CW-1:0] r_cnt;
  logic          r_bus_req;
  logic          r_bus_we;
  logic [31:0]   r_bus_addr;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_bus_wdata;
  logic [4:0]    r_rd;
  logic          r_reg_en;
  logic [2:0]    r_funct3;
  logic [1:0]    r_lsb;
  logic          r_we;
  logic          r_err;
  logic [31:0]   r_rdata;

  logic          w_memop;
  logic          w_legal;
  logic          w_aligned;
  logic          w_issue;
  logic          w_timeout;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic [7:0]    w_byte;
  logic [15:0]   w_half;
  logic [31:0]   w_load_data;

  assign w_memop   = ex_valid & (mem_read | mem_write);
  assign w_timeout = (BUS_TIMEOUT != 0) && (r_cnt == LAST);

  always_comb begin
    w_legal = 1'b0;
    if (mem_read && !mem_write)
      w_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    else if (mem_write && !mem_read)
      w_legal = funct3 inside {3'b000, 3'b001, 3'b010};
  end

  always_comb begin
    case (funct3[1:0])
      2'b01:   w_aligned = ~alu_result[0];
      2'b10:   w_aligned = (alu_result[1:0] == 2'b00);
      default: w_aligned = 1'b1;
    endcase
  end

  // Stores replicate the data across lanes so the memory only needs byte enables.
  always_comb begin
    w_be    = 4'b1111;
    w_wdata = store_data;
    case (funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << alu_result[1:0];
        w_wdata = {4{store_data[7:0]}};
      end
      2'b01: begin
        w_be    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{store_data[15:0]}};
      end
      default: ;
    endcase
    if (!mem_write)
      w_be = 4'b1111;
  end

  always_comb begin
    case (r_lsb)
      2'd0:    w_byte = r_rdata[7:0];
      2'd1:    w_byte = r_rdata[15:8];
      2'd2:    w_byte = r_rdata[23:16];
      default: w_byte = r_rdata[31:24];
    endcase
    w_half = r_lsb[1] ? r_rdata[31:16] : r_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load_data = {24'h0, w_byte};
      3'b001:  w_load_data = {{16{w_half[15]}}, w_half};
      3'b101:  w_load_data = {16'h0, w_half};
      default: w_load_data = r_rdata;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_issue    = 1'b0;
    data_out   = alu_result;
    rd_out     = rd_in;
    reg_en_out = 1'b0;
    stall      = 1'b0;
    addr_fault = 1'b0;
    bus_error  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_memop) begin
          reg_en_out = reg_en_in & ex_valid;
        end else if (!(w_legal && w_aligned)) begin
          addr_fault = 1'b1;
        end else begin
          stall   = 1'b1;
          w_issue = 1'b1;
          w_next  = S_WAIT;
        end
      end
      S_WAIT: begin
        stall = 1'b1;
        if (bus_ack || w_timeout)
          w_next = S_RESP;
      end
      S_RESP: begin
        data_out   = (r_we || r_err) ? 32'h0 : w_load_data;
        rd_out     = r_rd;
        reg_en_out = r_reg_en & ~r_we & ~r_err;
        bus_error  = r_err;
        w_next     = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_bus_req   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_addr  <= 32'h0;
      r_bus_be    <= 4'h0;
      r_bus_wdata <= 32'h0;
      r_rd        <= 5'h0;
      r_reg_en    <= 1'b0;
      r_funct3    <= 3'h0;
      r_lsb       <= 2'h0;
      r_we        <= 1'b0;
      r_err       <= 1'b0;
      r_rdata     <= 32'h0;
    end else if (w_issue) begin
      r_cnt       <= '0;
      r_bus_req   <= 1'b1;
      r_bus_we    <= mem_write;
      r_bus_addr  <= {alu_result[31:2], 2'b00};
      r_bus_be    <= w_be;
      r_bus_wdata <= w_wdata;
      r_rd        <= rd_in;
      r_reg_en    <= reg_en_in;
      r_funct3    <= funct3;
      r_lsb       <= alu_result[1:0];
      r_we        <= mem_write;
      r_err       <= 1'b0;
    end else if (r_state == S_WAIT) begin
      // Ack takes priority over an expiring timeout in the same cycle.
      if (bus_ack) begin
        r_rdata   <= bus_rdata;
        r_bus_req <= 1'b0;
        r_cnt     <= '0;
      end else if (w_timeout) begin
        r_bus_req <= 1'b0;
        r_err     <= 1'b1;
        r_cnt     <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign bus_req   = r_bus_req;
  assign bus_we    = r_bus_we;
  assign bus_addr  = r_bus_addr;
  assign bus_be    = r_bus_be;
  assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - scoreboard bench for mem_stage: directed ops, queued expectations, decoupled monitor
module tb_mem_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        ex_valid = 1'b0;
  logic        mem_read = 1'b0;
  logic        mem_write = 1'b0;
  logic [2:0]  funct3 = 3'h0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd_in = 5'h0;
  logic        reg_en_in = 1'b0;
  logic [31:0] data_out;
  logic [4:0]  rd_out;
  logic        reg_en_out;
  logic        stall;
  logic        addr_fault;
  logic        bus_error;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'h0;

  mem_stage #(.BUS_TIMEOUT(4)) dut (
    .clock(clock), .reset(reset), .ex_valid(ex_valid), .mem_read(mem_read),
    .mem_write(mem_write), .funct3(funct3), .alu_result(alu_result),
    .store_data(store_data), .rd_in(rd_in), .reg_en_in(reg_en_in),
    .data_out(data_out), .rd_out(rd_out), .reg_en_out(reg_en_out), .stall(stall),
    .addr_fault(addr_fault), .bus_error(bus_error), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  rd;
    logic        ren;
    logic        fault;
    logic        err;
    logic        chk_dr;
    int          stalls;
  } ret_t;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    int          cycles;
  } bus_t;

  ret_t        ret_q[$];
  bus_t        bus_q[$];
  int          applied = 0;
  int          fails = 0;
  int          ack_delay = 0;
  logic [31:0] mem_rdata = 32'h0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    applied++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic exp_ret(input logic [31:0] d, input logic [4:0] r, input logic ren,
                         input logic flt, input logic err, input logic cdr, input int st);
    ret_t e;
    e.data = d; e.rd = r; e.ren = ren; e.fault = flt; e.err = err; e.chk_dr = cdr; e.stalls = st;
    ret_q.push_back(e);
  endtask

  task automatic exp_bus(input logic we, input logic [31:0] a, input logic [3:0] be,
                         input logic [31:0] wd, input int cyc);
    bus_t e;
    e.we = we; e.addr = a; e.be = be; e.wdata = wd; e.cycles = cyc;
    bus_q.push_back(e);
  endtask

  // Memory responder: acks in the ack_delay-th cycle that bus_req is seen high (0 = never).
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(negedge clock);
      if (bus_req) begin
        cnt++;
        bus_ack   = (ack_delay != 0) && (cnt == ack_delay);
        bus_rdata = bus_ack ? mem_rdata : 32'h0;
      end else begin
        cnt     = 0;
        bus_ack = 1'b0;
      end
    end
  end

  // Monitor: pops and checks bus requests and retirements as the DUT presents them.
  initial begin
    int   stall_cnt;
    int   req_cnt;
    logic prev_req;
    bus_t cur;
    ret_t e;
    stall_cnt = 0; req_cnt = 0; prev_req = 1'b0;
    cur.cycles = 0;
    forever begin
      @(negedge clock);
      if (bus_req && !prev_req) begin
        req_cnt = 0;
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_req", 32'(bus_req), 32'h0);
        end else begin
          cur = bus_q.pop_front();
          chk("bus_we", 32'(bus_we), 32'(cur.we));
          chk("bus_addr", bus_addr, cur.addr);
          chk("bus_be", 32'(bus_be), 32'(cur.be));
          chk("bus_wdata", bus_wdata, cur.wdata);
        end
      end
      if (bus_req) req_cnt++;
      if (!bus_req && prev_req)
        chk("bus_req_cycles", 32'(req_cnt), 32'(cur.cycles));
      prev_req = bus_req;
      if (reset) begin
        stall_cnt = 0;
      end else if (ex_valid && stall) begin
        stall_cnt++;
      end else if (ex_valid) begin
        if (ret_q.size() == 0) begin
          chk("unexpected_retire", 32'(ex_valid), 32'h0);
        end else begin
          e = ret_q.pop_front();
          if (e.chk_dr) begin
            chk("data_out", data_out, e.data);
            chk("rd_out", 32'(rd_out), 32'(e.rd));
          end
          chk("reg_en_out", 32'(reg_en_out), 32'(e.ren));
          chk("addr_fault", 32'(addr_fault), 32'(e.fault));
          chk("bus_error", 32'(bus_error), 32'(e.err));
          chk("stall_cycles", 32'(stall_cnt), 32'(e.stalls));
        end
        stall_cnt = 0;
      end
    end
  end

  task automatic op(input logic r, input logic w, input logic [2:0] f3, input logic [31:0] a,
                    input logic [31:0] sd, input logic [4:0] rdi, input logic ren,
                    input int ackd, input logic [31:0] rdat);
    int n;
    ack_delay = ackd; mem_rdata = rdat;
    mem_read = r; mem_write = w; funct3 = f3; alu_result = a; store_data = sd;
    rd_in = rdi; reg_en_in = ren; ex_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (stall && n < 50);
    if (stall) chk("retire_timeout", 32'(stall), 32'h0);
    @(posedge clock);
    #1;
    ex_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got running expected finished");
    $fatal(1);
  end

  initial begin
    #12;
    chk("rst_bus_req", 32'(bus_req), 32'h0);
    chk("rst_bus_addr", bus_addr, 32'h0);
    chk("rst_bus_be", 32'(bus_be), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_reg_en_out", 32'(reg_en_out), 32'h0);
    chk("rst_flags", 32'({addr_fault, bus_error}), 32'h0);
    @(posedge clock); #1; reset = 1'b0;

    exp_ret(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    op(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 1, 32'h0);

    exp_bus(1'b0, 32'h0000_1000, 4'b1111, 32'h0, 2);
    exp_ret(32'hFFFF_FF80, 5'd7, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    op(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7, 1'b1, 2, 32'h80FF_FF7F);

    exp_bus(1'b0, 32'h0000_1000, 4'b1111, 32'h0, 2);
    exp_ret(32'h0000_0080, 5'd8, 1'b1, 1'b0, 1'b0, 1'b1, 3);
    op(1'b1, 1'b0, 3'b100, 32'h0000_1003, 32'h0, 5'd8, 1'b1, 2, 32'h80FF_FF7F);

    exp_bus(1'b1, 32'h0000_2000, 4'b1100, 32'hBEEF_BEEF, 1);
    exp_ret(32'h0, 5'd3, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    op(1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'hDEAD_BEEF, 5'd3, 1'b1, 1, 32'h0);

    exp_ret(32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    op(1'b1, 1'b0, 3'b010, 32'h0000_3002, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    exp_ret(32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    op(1'b1, 1'b0, 3'b011, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    exp_ret(32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    op(1'b1, 1'b1, 3'b010, 32'h0000_3000, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    exp_ret(32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    op(1'b1, 1'b0, 3'b001, 32'h0000_4001, 32'h0, 5'd9, 1'b1, 1, 32'h0);
    exp_ret(32'h0, 5'd9, 1'b0, 1'b1, 1'b0, 1'b0, 0);
    op(1'b0, 1'b1, 3'b100, 32'h0000_7003, 32'h0, 5'd9, 1'b0, 1, 32'h0);

    exp_bus(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 1);
    exp_ret(32'hFFFF_8001, 5'd10, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    op(1'b1, 1'b0, 3'b001, 32'h0000_4002, 32'h0, 5'd10, 1'b1, 1, 32'h8001_7FFF);

    exp_bus(1'b0, 32'h0000_4000, 4'b1111, 32'h0, 1);
    exp_ret(32'h0000_FFFE, 5'd11, 1'b1, 1'b0, 1'b0, 1'b1, 2);
    op(1'b1, 1'b0, 3'b101, 32'h0000_4000, 32'h0, 5'd11, 1'b1, 1, 32'h8001_FFFE);

    exp_bus(1'b0, 32'h0000_5000, 4'b1111, 32'h0, 3);
    exp_ret(32'h1234_5678, 5'd12, 1'b1, 1'b0, 1'b0, 1'b1, 4);
    op(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd12, 1'b1, 3, 32'h1234_5678);

    exp_bus(1'b1, 32'h0000_6000, 4'b0010, 32'hA5A5_A5A5, 1);
    exp_ret(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    op(1'b0, 1'b1, 3'b000, 32'h0000_6001, 32'h0000_00A5, 5'd0, 1'b0, 1, 32'h0);

    exp_bus(1'b1, 32'h0000_6004, 4'b1111, 32'hCAFE_F00D, 1);
    exp_ret(32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 2);
    op(1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'hCAFE_F00D, 5'd0, 1'b0, 1, 32'h0);

    exp_bus(1'b0, 32'h0000_7000, 4'b1111, 32'h0, 4);
    exp_ret(32'h0, 5'd13, 1'b0, 1'b0, 1'b1, 1'b1, 5);
    op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd13, 1'b1, 0, 32'h0);

    exp_bus(1'b0, 32'h0000_7000, 4'b1111, 32'h0, 4);
    exp_ret(32'h0BAD_CAFE, 5'd14, 1'b1, 1'b0, 1'b0, 1'b1, 5);
    op(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd14, 1'b1, 4, 32'h0BAD_CAFE);

    // Reset in the middle of a WAIT: the request is abandoned and never retires.
    exp_bus(1'b0, 32'h0000_8000, 4'b1111, 32'h0, 2);
    ack_delay = 0;
    mem_read = 1'b1; mem_write = 1'b0; funct3 = 3'b010; alu_result = 32'h0000_8000;
    store_data = 32'h0; rd_in = 5'd15; reg_en_in = 1'b1; ex_valid = 1'b1;
    @(posedge clock); @(posedge clock); @(posedge clock);
    #3;
    reset = 1'b1; ex_valid = 1'b0;
    #1;
    chk("mid_rst_bus_req", 32'(bus_req), 32'h0);
    @(posedge clock); @(posedge clock); #1;
    reset = 1'b0;
    #1;
    chk("post_rst_stall", 32'(stall), 32'h0);
    chk("post_rst_reg_en_out", 32'(reg_en_out), 32'h0);

    exp_ret(32'h0000_00AB, 5'd1, 1'b1, 1'b0, 1'b0, 1'b1, 0);
    op(1'b0, 1'b0, 3'b000, 32'h0000_00AB, 32'h0, 5'd1, 1'b1, 1, 32'h0);

    repeat (3) @(posedge clock);
    chk("ret_q_drained", 32'(ret_q.size()), 32'h0);
    chk("bus_q_drained", 32'(bus_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
    $finish;
  end

endmodule
